// File: rtl/fibo_series_checker_pkg.sv
// Shared definitions for the Fibonacci series checker: FSM state encoding.
package fibo_series_checker_pkg;

  // ACQ0/ACQ1 capture the two seed terms; TRACK verifies every later term.
  typedef enum logic [1:0] {
    ACQ0  = 2'd0,
    ACQ1  = 2'd1,
    TRACK = 2'd2
  } state_t;

endpackage

// File: rtl/fibo_sat_counter.sv
// Saturating event counter: counts inc pulses, sticks at all-ones.
module fibo_sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  // Count up on inc, hold at the maximum value instead of wrapping
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/fibo_series_checker.sv
// Observational monitor for a Fibonacci generator: locks onto the series from
// two seed terms, then checks each new term against the modular sum of the
// previous two, flagging mismatches and generator restarts.
module fibo_series_checker
  import fibo_series_checker_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] fibo_in,
  input  logic             in_valid,
  output logic             lock,
  output logic             err,
  output logic             restart,
  output logic [WIDTH-1:0] expected,
  output logic [CNT_W-1:0] term_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] restart_cnt
);

  // Term sum with the carry discarded, matching the generator's wraparound
  function automatic logic [WIDTH-1:0] add_mod(input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y);
    return x + y;
  endfunction

  state_t           state_p0;
  logic [WIDTH-1:0] a_p0;
  logic [WIDTH-1:0] b_p0;

  logic [WIDTH-1:0] exp_sum;
  logic             is_match;
  logic             in_track;
  logic             term_inc;
  logic             err_inc;
  logic             restart_inc;

  // Classify the incoming term against the current prediction
  always_comb begin
    exp_sum     = add_mod(a_p0, b_p0);
    is_match    = (fibo_in == exp_sum);
    in_track    = in_valid && (state_p0 == TRACK);
    term_inc    = in_track && is_match;
    restart_inc = in_track && !is_match && (fibo_in == '0);
    err_inc     = in_track && !is_match && (fibo_in != '0);
  end

  // Acquisition/tracking FSM with registered lock, expected and event pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      state_p0 <= ACQ0;
      a_p0     <= '0;
      b_p0     <= '0;
      lock     <= 1'b0;
      expected <= '0;
      err      <= 1'b0;
      restart  <= 1'b0;
    end else begin
      err     <= 1'b0;
      restart <= 1'b0;
      case (state_p0)
        ACQ0: begin
          if (in_valid) begin
            a_p0     <= fibo_in;
            state_p0 <= ACQ1;
          end
        end
        ACQ1: begin
          if (in_valid) begin
            b_p0     <= fibo_in;
            lock     <= 1'b1;
            expected <= add_mod(a_p0, fibo_in);
            state_p0 <= TRACK;
          end
        end
        TRACK: begin
          if (in_valid) begin
            if (is_match) begin
              // A legitimately expected zero lands here, not in restart
              a_p0     <= b_p0;
              b_p0     <= fibo_in;
              expected <= add_mod(b_p0, fibo_in);
            end else if (fibo_in == '0) begin
              // Generator started over: the zero is the new first seed
              restart  <= 1'b1;
              a_p0     <= '0;
              lock     <= 1'b0;
              expected <= '0;
              state_p0 <= ACQ1;
            end else begin
              // Resynchronise using the bad term as the new first seed
              err      <= 1'b1;
              a_p0     <= fibo_in;
              lock     <= 1'b0;
              expected <= '0;
              state_p0 <= ACQ1;
            end
          end
        end
        default: begin
          state_p0 <= ACQ0;
          lock     <= 1'b0;
          expected <= '0;
        end
      endcase
    end
  end

  fibo_sat_counter #(.CNT_W(CNT_W)) u_term_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (term_inc),
    .count (term_cnt)
  );

  fibo_sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (err_inc),
    .count (err_cnt)
  );

  fibo_sat_counter #(.CNT_W(CNT_W)) u_restart_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (restart_inc),
    .count (restart_cnt)
  );

endmodule
